// File: rtl/xheep_obi_arb_pkg.sv
// Shared OBI types and helpers for the X-HEEP external-port arbiter.
package xheep_obi_arb_pkg;

  localparam logic [3:0]  OBI_BE_FULL   = 4'b1111;
  localparam logic [31:0] SOC_CTRL_ADDR = 32'h2000_000c;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  localparam obi_req_t OBI_REQ_IDLE = '{req: 1'b0, we: 1'b0, be: OBI_BE_FULL,
                                        addr: '0, wdata: '0};

  // Wide enough for any practical requester count.
  localparam int unsigned ARB_IDX_MAX_W = 8;
  typedef logic [ARB_IDX_MAX_W-1:0] arb_idx_t;

  function automatic int unsigned IdxW(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xheep_obi_ext_arbiter_if.sv
// OBI bus bundle for N ports: request/lock flow master->slave, response back.
interface xheep_obi_ext_arbiter_if
  import xheep_obi_arb_pkg::*;
#(
  parameter int unsigned N = 1
) ();

  obi_req_t       req  [N];
  logic [N-1:0]   lock;
  obi_resp_t      resp [N];

  modport master (output req, output lock, input resp);
  modport slave  (input req, input lock, output resp);

endinterface

// File: rtl/xheep_obi_id_fifo.sv
// Requester-index FIFO tracking granted-but-unanswered OBI transactions.
module xheep_obi_id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      mem   <= '{default: '0};
    end else begin
      if (do_push) begin
        mem[wr_q] <= din;
        wr_q      <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/xheep_obi_ext_arbiter.sv
// Round-robin arbiter with lock and outstanding tracking in front of the
// single X-HEEP external OBI slave port.
module xheep_obi_ext_arbiter
  import xheep_obi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  xheep_obi_ext_arbiter_if.slave  masters,
  xheep_obi_ext_arbiter_if.master obi,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int unsigned IW = IdxW(NUM_REQ);
  typedef logic [IW-1:0] idx_t;

  idx_t               rr_ptr_q, held_q, lock_owner_q, winner, fifo_head;
  logic               held_valid_q, lock_valid_q, err_q;
  logic               found, lock_active, fifo_full, fifo_empty;
  logic               issue, handshake, pop;
  logic [NUM_REQ-1:0] req_valid;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) req_valid[i] = masters.req[i].req;
  end

  assign lock_active = lock_valid_q && masters.lock[lock_owner_q];

  // A held (ungranted) request outranks the scan; an active lock outranks both.
  always_comb begin
    winner = rr_ptr_q;
    found  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[idx_t'((32'(rr_ptr_q) + k) % NUM_REQ)]) begin
        winner = idx_t'((32'(rr_ptr_q) + k) % NUM_REQ);
        found  = 1'b1;
      end
    end
    if (held_valid_q) begin
      winner = held_q;
      found  = req_valid[held_q];
    end
    if (lock_active) begin
      winner = lock_owner_q;
      found  = req_valid[lock_owner_q];
    end
  end

  assign issue     = found && !fifo_full;
  assign handshake = issue && obi.resp[0].gnt;
  assign pop       = obi.resp[0].rvalid && !fifo_empty;
  assign obi.lock  = '0;

  always_comb begin
    obi.req[0] = OBI_REQ_IDLE;
    if (issue) begin
      obi.req[0]     = masters.req[winner];
      obi.req[0].req = 1'b1;
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      masters.resp[i]     = '0;
      masters.resp[i].gnt = handshake && (winner == idx_t'(i));
      if (pop && (fifo_head == idx_t'(i))) begin
        masters.resp[i].rvalid = 1'b1;
        masters.resp[i].rdata  = obi.resp[0].rdata;
      end
    end
  end

  xheep_obi_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IW)
  ) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (handshake),
    .pop   (pop),
    .din   (winner),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      held_q       <= '0;
      held_valid_q <= 1'b0;
      lock_owner_q <= '0;
      lock_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      held_valid_q <= issue && !obi.resp[0].gnt;
      if (issue && !obi.resp[0].gnt) held_q <= winner;
      if (handshake) begin
        rr_ptr_q <= (winner == idx_t'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end
      if (handshake && masters.lock[winner]) begin
        lock_owner_q <= winner;
        lock_valid_q <= 1'b1;
      end else if (lock_valid_q && !masters.lock[lock_owner_q]) begin
        lock_valid_q <= 1'b0;
      end
      if (obi.resp[0].rvalid && fifo_empty) err_q <= 1'b1;
    end
  end

  assign busy_o = (|req_valid) || !fifo_empty;
  assign err_o  = err_q;

endmodule

// File: tb/tb_xheep_obi_ext_arbiter.sv
// Scoreboarded bench: bench-side slave answers with addr^KEY, responses are
// matched against the issuing master predicted by a round-robin model.
module tb_xheep_obi_ext_arbiter;
  import xheep_obi_arb_pkg::*;

  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  obi_req_t    mreq [2];
  logic [1:0]  mlock;
  logic        slv_gnt = 1'b0, slv_rvalid = 1'b0, slv_rsp_en = 1'b0, spur = 1'b0;
  logic [31:0] slv_rdata = '0;
  logic        busy_o, err_o;

  int unsigned errors = 0, checks = 0, rr_model = 0;

  typedef struct {
    int unsigned idx;
    logic [31:0] data;
  } exp_t;
  exp_t        exp_q [$];
  exp_t        mon_e;
  logic [31:0] slv_q [$];
  logic [1:0]  gv;

  xheep_obi_ext_arbiter_if #(.N(2)) m_bus ();
  xheep_obi_ext_arbiter_if #(.N(1)) s_bus ();

  assign m_bus.req    = mreq;
  assign m_bus.lock   = mlock;
  assign s_bus.resp[0] = '{gnt: slv_gnt, rvalid: slv_rvalid, rdata: slv_rdata};
  assign gv = {m_bus.resp[1].gnt, m_bus.resp[0].gnt};

  xheep_obi_ext_arbiter #(
    .NUM_REQ         (2),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .masters (m_bus),
    .obi     (s_bus),
    .busy_o  (busy_o),
    .err_o   (err_o)
  );

  // Slave: answers each granted request one cycle later when enabled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slv_q.delete();
      slv_rvalid <= 1'b0;
      slv_rdata  <= '0;
    end else begin
      if (s_bus.req[0].req && slv_gnt) slv_q.push_back(s_bus.req[0].addr ^ KEY);
      if (spur) begin
        slv_rvalid <= 1'b1;
        slv_rdata  <= 32'hDEAD_BEEF;
      end else if (slv_rsp_en && slv_q.size() > 0) begin
        slv_rvalid <= 1'b1;
        slv_rdata  <= slv_q.pop_front();
      end else begin
        slv_rvalid <= 1'b0;
        slv_rdata  <= '0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (m_bus.resp[i].rvalid === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rvalid_unexpected: master %0d got rvalid rdata %h, required none", i, m_bus.resp[i].rdata);
          end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.idx != i || m_bus.resp[i].rdata !== mon_e.data) begin
              errors++;
              $display("FAIL rsp_route: got master %0d rdata %h, required master %0d rdata %h",
                       i, m_bus.resp[i].rdata, mon_e.idx, mon_e.data);
            end
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int unsigned m, input logic r, input logic we,
                         input logic [31:0] a, input logic lk);
    mreq[m]  = '{req: r, we: we, be: OBI_BE_FULL, addr: a, wdata: ~a};
    mlock[m] = lk;
  endtask

  task automatic idle_all();
    set_req(0, 1'b0, 1'b0, '0, 1'b0);
    set_req(1, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic expect_rsp(input int unsigned m, input logic [31:0] a);
    exp_q.push_back('{m, a ^ KEY});
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (gv !== 2'b00 || s_bus.req[0].req !== 1'b0) begin
      errors++; $display("FAIL reset_gnt_req: gnt %b req %b, required 00 0", gv, s_bus.req[0].req);
    end
    checks++;
    if (s_bus.req[0].be !== 4'b1111 || s_bus.req[0].addr !== '0 || s_bus.req[0].wdata !== '0) begin
      errors++; $display("FAIL reset_fields: be %b addr %h wdata %h, required 1111 0 0",
                         s_bus.req[0].be, s_bus.req[0].addr, s_bus.req[0].wdata);
    end
    checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b0) begin
      errors++; $display("FAIL reset_flags: busy %b err %b, required 0 0", busy_o, err_o);
    end
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_single_master();
    logic [31:0] a;
    slv_gnt = 1'b1; slv_rsp_en = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      cyc();
      a = 32'(k * 4);
      set_req(0, 1'b1, 1'b1, a, 1'b0);
      expect_rsp(0, a);
      @(negedge clk);
      checks++;
      if (gv !== 2'b01 || s_bus.req[0].addr !== a || s_bus.req[0].we !== 1'b1) begin
        errors++; $display("FAIL single_gnt: gnt %b addr %h we %b, required 01 %h 1", gv, s_bus.req[0].addr, s_bus.req[0].we, a);
      end
    end
    rr_model = 1;
    cyc(); idle_all();
    repeat (3) cyc();
    checks++;
    if (exp_q.size() != 0 || err_o !== 1'b0) begin
      errors++; $display("FAIL single_drain: pending %0d err %b, required 0 0", exp_q.size(), err_o);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] a0, a1;
    int unsigned w;
    a0 = 32'h100; a1 = 32'h200;
    for (int c = 0; c < 6; c++) begin
      cyc();
      set_req(0, 1'b1, 1'b0, a0, 1'b0);
      set_req(1, 1'b1, 1'b0, a1, 1'b0);
      w = rr_model;
      expect_rsp(w, (w == 1) ? a1 : a0);
      @(negedge clk);
      checks++;
      if (gv !== ((w == 1) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rr_alternate: cycle %0d gnt %b, required master %0d", c, gv, w);
      end
      if (w == 1) a1 += 4; else a0 += 4;
      rr_model = 1 - w;
    end
    cyc(); idle_all();
    repeat (3) cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rr_drain: pending %0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_lock();
    cyc();
    set_req(0, 1'b1, 1'b1, 32'h300, 1'b1);
    set_req(1, 1'b0, 1'b0, '0, 1'b0);
    expect_rsp(0, 32'h300);
    @(negedge clk);
    checks++;
    if (gv !== 2'b01) begin errors++; $display("FAIL lock_first: gnt %b, required 01", gv); end
    for (int unsigned j = 1; j < 3; j++) begin
      cyc();
      set_req(0, 1'b1, 1'b1, 32'h300 + 32'(j * 4), 1'b1);
      set_req(1, 1'b1, 1'b0, 32'h400, 1'b0);
      expect_rsp(0, 32'h300 + 32'(j * 4));
      @(negedge clk);
      checks++;
      if (gv !== 2'b01) begin errors++; $display("FAIL lock_hold: word %0d gnt %b, required 01", j, gv); end
    end
    cyc();
    set_req(0, 1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    checks++;
    if (gv !== 2'b00 || s_bus.req[0].req !== 1'b0) begin
      errors++; $display("FAIL lock_owner_idle: gnt %b req %b, required 00 0", gv, s_bus.req[0].req);
    end
    cyc();
    set_req(0, 1'b0, 1'b0, '0, 1'b0);
    expect_rsp(1, 32'h400);
    @(negedge clk);
    checks++;
    if (gv !== 2'b10) begin errors++; $display("FAIL lock_release: gnt %b, required 10", gv); end
    rr_model = 0;
    cyc(); idle_all();
    repeat (3) cyc();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL lock_drain: pending %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_outstanding();
    slv_rsp_en = 1'b0;
    cyc();
    set_req(1, 1'b1, 1'b0, 32'h500, 1'b0);
    expect_rsp(1, 32'h500);
    @(negedge clk);
    checks++;
    if (gv !== 2'b10) begin errors++; $display("FAIL out_first: gnt %b, required 10", gv); end
    cyc();
    set_req(1, 1'b0, 1'b0, '0, 1'b0);
    set_req(0, 1'b1, 1'b0, 32'h600, 1'b0);
    expect_rsp(0, 32'h600);
    @(negedge clk);
    checks++;
    if (gv !== 2'b01) begin errors++; $display("FAIL out_second: gnt %b, required 01", gv); end
    cyc();
    set_req(0, 1'b0, 1'b0, '0, 1'b0);
    set_req(1, 1'b1, 1'b0, 32'h504, 1'b0);
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      checks++;
      if (gv !== 2'b00 || s_bus.req[0].req !== 1'b0 || busy_o !== 1'b1) begin
        errors++; $display("FAIL full_block: gnt %b req %b busy %b, required 00 0 1", gv, s_bus.req[0].req, busy_o);
      end
      if (s == 0) cyc();
    end
    slv_rsp_en = 1'b1;
    cyc();
    @(negedge clk);
    checks++;
    if (gv !== 2'b00 || s_bus.req[0].req !== 1'b0) begin
      errors++; $display("FAIL full_no_bypass: gnt %b req %b, required 00 0", gv, s_bus.req[0].req);
    end
    cyc();
    expect_rsp(1, 32'h504);
    @(negedge clk);
    checks++;
    if (gv !== 2'b10) begin errors++; $display("FAIL full_resume: gnt %b, required 10", gv); end
    rr_model = 0;
    cyc(); idle_all();
    repeat (3) cyc();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL out_drain: pending %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_gnt_stall();
    slv_gnt = 1'b0;
    cyc();
    set_req(1, 1'b1, 1'b1, 32'h700, 1'b0);
    @(negedge clk);
    checks++;
    if (s_bus.req[0].req !== 1'b1 || s_bus.req[0].addr !== 32'h700) begin
      errors++; $display("FAIL stall_m1_fields: req %b addr %h, required 1 00000700", s_bus.req[0].req, s_bus.req[0].addr);
    end
    for (int s = 1; s < 5; s++) begin
      cyc();
      set_req(0, 1'b1, 1'b0, 32'h800, 1'b0);
      @(negedge clk);
      checks++;
      if (s_bus.req[0].addr !== 32'h700 || s_bus.req[0].we !== 1'b1 || gv !== 2'b00) begin
        errors++; $display("FAIL stall_hold: cycle %0d addr %h we %b gnt %b, required 00000700 1 00",
                           s, s_bus.req[0].addr, s_bus.req[0].we, gv);
      end
    end
    cyc();
    slv_gnt = 1'b1;
    expect_rsp(1, 32'h700);
    @(negedge clk);
    checks++;
    if (gv !== 2'b10) begin errors++; $display("FAIL stall_release: gnt %b, required 10", gv); end
    cyc();
    set_req(1, 1'b0, 1'b0, '0, 1'b0);
    expect_rsp(0, 32'h800);
    @(negedge clk);
    checks++;
    if (gv !== 2'b01 || s_bus.req[0].addr !== 32'h800) begin
      errors++; $display("FAIL stall_then_m0: gnt %b addr %h, required 01 00000800", gv, s_bus.req[0].addr);
    end
    rr_model = 1;
    cyc(); idle_all();
    repeat (3) cyc();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drain: pending %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_spurious();
    cyc();
    spur = 1'b1;
    cyc();
    spur = 1'b0;
    @(negedge clk);
    checks++;
    if (m_bus.resp[0].rvalid !== 1'b0 || m_bus.resp[1].rvalid !== 1'b0 || err_o !== 1'b0) begin
      errors++; $display("FAIL spur_dropped: rvalid %b%b err %b, required 00 0",
                         m_bus.resp[1].rvalid, m_bus.resp[0].rvalid, err_o);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL spur_err: err %b, required 1", err_o); end
    repeat (3) cyc();
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky: err %b, required 1", err_o); end
  endtask

  task automatic test_reset_midflight();
    slv_rsp_en = 1'b0;
    cyc();
    set_req(0, 1'b1, 1'b0, 32'h900, 1'b0);
    @(negedge clk);
    checks++;
    if (gv !== 2'b01) begin errors++; $display("FAIL mid_gnt: gnt %b, required 01", gv); end
    cyc();
    idle_all();
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL busy_outstanding: busy %b, required 1", busy_o); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b0 || gv !== 2'b00) begin
      errors++; $display("FAIL rst_flush: busy %b err %b gnt %b, required 0 0 00", busy_o, err_o, gv);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rr_model = 0;
    slv_rsp_en = 1'b1;
    cyc();
    set_req(1, 1'b1, 1'b0, 32'hA00, 1'b0);
    expect_rsp(1, 32'hA00);
    @(negedge clk);
    checks++;
    if (gv !== 2'b10) begin errors++; $display("FAIL post_rst_gnt: gnt %b, required 10", gv); end
    cyc(); idle_all();
    repeat (3) cyc();
    checks++;
    if (exp_q.size() != 0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL post_rst_idle: pending %0d busy %b, required 0 0", exp_q.size(), busy_o);
    end
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation still running at %0t, required completion", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_master();
    test_round_robin();
    test_lock();
    test_outstanding();
    test_gnt_stall();
    test_spurious();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
